// File: rtl/tetris_pkg.sv
// Shared Tetris playfield definitions: default board geometry, row typedefs,
// empty-row constants, line-clear score table and the line-clear FSM state type.
package tetris_pkg;

    localparam int unsigned DEF_BOARD_W = 10;
    localparam int unsigned DEF_BOARD_H = 20;
    localparam int unsigned DEF_TYPE_W  = 3;

    typedef logic [DEF_BOARD_W-1:0]            row_fill_t;
    typedef logic [DEF_TYPE_W*DEF_BOARD_W-1:0] row_type_t;

    localparam row_fill_t EMPTY_ROW_FILL = '0;
    localparam row_type_t EMPTY_ROW_TYPE = '0;

    localparam logic [9:0] SCORE_1 = 10'd100;
    localparam logic [9:0] SCORE_2 = 10'd300;
    localparam logic [9:0] SCORE_3 = 10'd500;
    localparam logic [9:0] SCORE_4 = 10'd800;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFill,
        StDone
    } lc_state_t;

    // Points awarded for a single clear; four or more rows saturate at the tetris value.
    function automatic logic [9:0] score_for(input int unsigned cleared);
        logic [9:0] pts;
        case (cleared)
            0:       pts = 10'd0;
            1:       pts = SCORE_1;
            2:       pts = SCORE_2;
            3:       pts = SCORE_3;
            default: pts = SCORE_4;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/line_clear_row_full.sv
// Combinational full-row detector: high when every cell of the row is occupied.
module line_clear_row_full
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W = DEF_BOARD_W
) (
    input  logic [BOARD_W-1:0] row_fill,
    output logic               full
);

    // Reduction AND over the occupancy bits of one row
    always_comb begin
        full = &row_fill;
    end

endmodule

// File: rtl/line_clear_seq.sv
// Sequential line-clear engine. Snapshots the board on start, scans one row per
// cycle bottom-up, compacts surviving rows downward in place, blanks the vacated
// top rows and presents count/mask/board with a one-cycle done pulse.
// Optional macro LINE_CLEAR_SCORE_EN enables the score_delta table; otherwise
// score_delta is tied to zero.
module line_clear_seq
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W = DEF_BOARD_W,
    parameter int unsigned BOARD_H = DEF_BOARD_H,
    parameter int unsigned TYPE_W  = DEF_TYPE_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [BOARD_W*BOARD_H-1:0]        cur_fill,
    input  logic [TYPE_W*BOARD_W*BOARD_H-1:0] cur_type,
    output logic                              busy,
    output logic                              done,
    output logic [BOARD_W*BOARD_H-1:0]        nxt_fill,
    output logic [TYPE_W*BOARD_W*BOARD_H-1:0] nxt_type,
    output logic [$clog2(BOARD_H+1)-1:0]      num_cleared,
    output logic [BOARD_H-1:0]                clear_mask,
    output logic [9:0]                        score_delta
);

    localparam int unsigned CW  = $clog2(BOARD_H + 1);
    localparam int unsigned RTW = TYPE_W * BOARD_W;
    localparam logic [CW-1:0] LAST_ROW = CW'(BOARD_H - 1);
    localparam logic [CW-1:0] NUM_ROWS = CW'(BOARD_H);

    lc_state_t state_q, state_d;
    logic [CW-1:0]      rd_q, rd_d;
    logic [CW-1:0]      wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BOARD_H-1:0] mask_q, mask_d;

    // Single work copy: compaction writes row wr while reading row rd, and wr <= rd,
    // so rows not yet scanned are never overwritten.
    logic [BOARD_W-1:0] work_fill_q [BOARD_H];
    logic [BOARD_W-1:0] work_fill_d [BOARD_H];
    logic [RTW-1:0]     work_type_q [BOARD_H];
    logic [RTW-1:0]     work_type_d [BOARD_H];

    logic [BOARD_W*BOARD_H-1:0]        flat_fill;
    logic [TYPE_W*BOARD_W*BOARD_H-1:0] flat_type;
    logic [BOARD_W*BOARD_H-1:0]        nxt_fill_q;
    logic [TYPE_W*BOARD_W*BOARD_H-1:0] nxt_type_q;
    logic [CW-1:0]                     num_cleared_q;
    logic [BOARD_H-1:0]                clear_mask_q;

    logic [CW-1:0]      rd_idx;
    logic [BOARD_W-1:0] rd_fill;
    logic [RTW-1:0]     rd_type;
    logic               rd_full;
    logic               load_out;

    // Current scan row; clamped so the mux stays in range once rd passes the top
    always_comb begin
        rd_idx  = (rd_q < NUM_ROWS) ? rd_q : '0;
        rd_fill = work_fill_q[rd_idx];
        rd_type = work_type_q[rd_idx];
    end

    line_clear_row_full #(
        .BOARD_W (BOARD_W)
    ) u_row_full (
        .row_fill (rd_fill),
        .full     (rd_full)
    );

    // Next-state logic: snapshot, scan/compact, blank top rows, present results
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        work_fill_d = work_fill_q;
        work_type_d = work_type_q;
        load_out    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    for (int r = 0; r < BOARD_H; r++) begin
                        work_fill_d[r] = cur_fill[r*BOARD_W +: BOARD_W];
                        work_type_d[r] = cur_type[r*RTW +: RTW];
                    end
                    rd_d    = '0;
                    wr_d    = '0;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (rd_full) begin
                    mask_d[rd_idx] = 1'b1;
                    cnt_d          = cnt_q + CW'(1);
                end else begin
                    work_fill_d[wr_q] = rd_fill;
                    work_type_d[wr_q] = rd_type;
                    wr_d              = wr_q + CW'(1);
                end
                rd_d = rd_q + CW'(1);
                if (rd_q == LAST_ROW) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                for (int r = 0; r < BOARD_H; r++) begin
                    if (CW'(r) >= wr_q) begin
                        work_fill_d[r] = '0;
                        work_type_d[r] = '0;
                    end
                end
                // Results register on the edge into DONE so they are valid with done
                load_out = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Flatten the blanked work board into output bus layout
    always_comb begin
        flat_fill = '0;
        flat_type = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            flat_fill[r*BOARD_W +: BOARD_W] = work_fill_d[r];
            flat_type[r*RTW +: RTW]         = work_type_d[r];
        end
    end

    // Control state and work board registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            for (int r = 0; r < BOARD_H; r++) begin
                work_fill_q[r] <= '0;
                work_type_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            work_fill_q <= work_fill_d;
            work_type_q <= work_type_d;
        end
    end

    // Result registers; hold until the next completed clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_fill_q    <= '0;
            nxt_type_q    <= '0;
            num_cleared_q <= '0;
            clear_mask_q  <= '0;
        end else if (load_out) begin
            nxt_fill_q    <= flat_fill;
            nxt_type_q    <= flat_type;
            num_cleared_q <= cnt_q;
            clear_mask_q  <= mask_q;
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [9:0] score_q;

    // Score registers alongside the other results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else if (load_out) begin
            score_q <= score_for(32'(cnt_q));
        end
    end

    assign score_delta = score_q;
`else
    assign score_delta = '0;
`endif

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign nxt_fill    = nxt_fill_q;
    assign nxt_type    = nxt_type_q;
    assign num_cleared = num_cleared_q;
    assign clear_mask  = clear_mask_q;

endmodule

// File: tb/tb_line_clear_seq.sv
// Scoreboard bench for line_clear_seq: stimulus pushes expected results with the
// cycle they are due; a monitor pops and compares on every done pulse.
module tb_line_clear_seq;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int T  = 3;
    localparam int CW = 5;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [W*H-1:0]     cur_fill;
    logic [T*W*H-1:0]   cur_type;
    logic               busy;
    logic               done;
    logic [W*H-1:0]     nxt_fill;
    logic [T*W*H-1:0]   nxt_type;
    logic [CW-1:0]      num_cleared;
    logic [H-1:0]       clear_mask;
    logic [9:0]         score_delta;

    line_clear_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cur_fill    (cur_fill),
        .cur_type    (cur_type),
        .busy        (busy),
        .done        (done),
        .nxt_fill    (nxt_fill),
        .nxt_type    (nxt_type),
        .num_cleared (num_cleared),
        .clear_mask  (clear_mask),
        .score_delta (score_delta)
    );

    typedef struct {
        int             cyc;
        logic [W*H-1:0]   fill;
        logic [T*W*H-1:0] typ;
        logic [CW-1:0]  cnt;
        logic [H-1:0]   mask;
        logic [9:0]     score;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [W-1:0]   bf [H];
    logic [T*W-1:0] bt [H];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Full rows get all-ones occupancy; others a distinct per-row pattern
    task automatic gen_board(input logic [H-1:0] full_rows);
        for (int r = 0; r < H; r++) begin
            if (full_rows[r]) begin
                bf[r] = '1;
                bt[r] = {W{3'd7}};
            end else begin
                bf[r] = W'(r * 37 + 1);
                for (int c = 0; c < W; c++)
                    bt[r][c*T +: T] = bf[r][c] ? T'((r + c) % 7 + 1) : '0;
            end
        end
    endtask

    task automatic drive_board();
        for (int r = 0; r < H; r++) begin
            cur_fill[r*W +: W]     = bf[r];
            cur_type[r*T*W +: T*W] = bt[r];
        end
    endtask

    task automatic scribble();
        for (int r = 0; r < H; r++) begin
            cur_fill[r*W +: W]     = W'($urandom);
            cur_type[r*T*W +: T*W] = (T*W)'($urandom);
        end
    endtask

    // Reference compaction: survivors keep order and move down; top rows blank
    task automatic push_exp(input logic [CW-1:0] cnt, input logic [H-1:0] mask,
                            input logic [9:0] sc, input int at);
        exp_t e;
        int   wr;
        e.fill = '0;
        e.typ  = '0;
        wr     = 0;
        for (int r = 0; r < H; r++) begin
            if (bf[r] != {W{1'b1}}) begin
                e.fill[wr*W +: W]     = bf[r];
                e.typ[wr*T*W +: T*W]  = bt[r];
                wr++;
            end
        end
        e.cyc  = at;
        e.cnt  = cnt;
        e.mask = mask;
`ifdef LINE_CLEAR_SCORE_EN
        e.score = sc;
`else
        e.score = (sc & 10'd0);
`endif
        sbq.push_back(e);
    endtask

    // Start one operation at the current negedge; done due 22 cycles later
    task automatic run(input logic [CW-1:0] cnt, input logic [H-1:0] mask,
                       input logic [9:0] sc, input bit expect_done);
        drive_board();
        if (expect_done) push_exp(cnt, mask, sc, cyc + 22);
        start = 1'b1;
        step(1);
        start = 1'b0;
        scribble();
        chk("busy_after_start", 640'(busy), 640'(1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
            sbq.delete();
        end
        step(1);
        chk("busy_after_done", 640'(busy), 640'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  640'(busy),        640'(0));
        chk({tag, "_done"},  640'(done),        640'(0));
        chk({tag, "_fill"},  640'(nxt_fill),    640'(0));
        chk({tag, "_type"},  640'(nxt_type),    640'(0));
        chk({tag, "_cnt"},   640'(num_cleared), 640'(0));
        chk({tag, "_mask"},  640'(clear_mask),  640'(0));
        chk({tag, "_score"}, 640'(score_delta), 640'(0));
    endtask

    // Monitor: every done pulse must match the oldest expected result and its cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 want none", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle",  640'(cyc),         640'(e.cyc));
                    chk("num_cleared", 640'(num_cleared), 640'(e.cnt));
                    chk("clear_mask",  640'(clear_mask),  640'(e.mask));
                    chk("nxt_fill",    640'(nxt_fill),    640'(e.fill));
                    chk("nxt_type",    640'(nxt_type),    640'(e.typ));
                    chk("score_delta", 640'(score_delta), 640'(e.score));
                end
            end
        end
    end

    initial begin
        int c0;
        rst_n    = 1'b0;
        start    = 1'b0;
        cur_fill = '0;
        cur_type = '0;
        step(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step(2);
        chk_reset_outputs("post_reset");

        // Empty board: nothing cleared, board unchanged
        for (int r = 0; r < H; r++) begin
            bf[r] = '0;
            bt[r] = '0;
        end
        run(5'd0, 20'h00000, 10'd0, 1'b1);
        wait_drain();

        // Rows 0-3 full, row 4 single cell of type 5 drops to row 0
        for (int r = 0; r < H; r++) begin
            bf[r] = '0;
            bt[r] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            bf[r] = '1;
            bt[r] = {W{3'd2}};
        end
        bf[4] = 10'h001;
        bt[4] = 30'd5;
        run(5'd4, 20'h0000F, 10'd800, 1'b1);
        wait_drain();
        chk("tetris_row0_fill", 640'(nxt_fill[W-1:0]), 640'(10'h001));
        chk("tetris_row0_type", 640'(nxt_type[T*W-1:0]), 640'(30'd5));

        // Non-contiguous rows 2, 7, 15
        gen_board(20'h08084);
        run(5'd3, 20'h08084, 10'd500, 1'b1);
        wait_drain();
        chk("noncontig_top3", 640'(nxt_fill[W*H-1 -: 3*W]), 640'(0));

        // Every row full
        gen_board(20'hFFFFF);
        run(5'd20, 20'hFFFFF, 10'd800, 1'b1);
        wait_drain();

        // Start at 0, 5 and 22 gives one run; next accepted only at 23
        gen_board(20'h00001);
        c0 = cyc;
        run(5'd1, 20'h00001, 10'd100, 1'b1);
        wait_cyc(c0 + 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_cyc(c0 + 22);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("idle_at_23", 640'(busy), 640'(0));
        gen_board(20'h00003);
        run(5'd2, 20'h00003, 10'd300, 1'b1);
        wait_drain();

        // Reset at cycle 10 of a run aborts with no done
        gen_board(20'h00010);
        c0 = cyc;
        run(5'd1, 20'h00010, 10'd100, 1'b0);
        wait_cyc(c0 + 10);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        step(2);
        rst_n = 1'b1;
        wait_cyc(c0 + 40);
        chk("abort_busy", 640'(busy), 640'(0));

        // Fresh run after abort, top two rows full
        gen_board(20'hC0000);
        run(5'd2, 20'hC0000, 10'd300, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_clear_seq.md
# line_clear_seq

Sequential, parametrised line-clear engine for the Tetris playfield. On a start pulse it snapshots the board, scans rows bottom-up one per cycle, drops every full row (any count, any pattern, not only four contiguous), compacts the survivors downward, blanks the vacated top rows, and reports count, mask and optional score. It sits between piece lock-down and the board register in the game controller.

## Interface
- BOARD_W, 10, cells per row
- BOARD_H, 20, rows; row 0 is the bottom
- TYPE_W, 3, piece-type bits per cell
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- cur_fill  in  BOARD_W*BOARD_H  occupancy; row r at [r*BOARD_W +: BOARD_W]
- cur_type  in  TYPE_W*BOARD_W*BOARD_H  cell types; row r at [r*TYPE_W*BOARD_W +: TYPE_W*BOARD_W]
- busy  out  1  high from cycle after accepted start through done cycle
- done  out  1  one-cycle pulse, results valid
- nxt_fill  out  BOARD_W*BOARD_H  compacted occupancy
- nxt_type  out  TYPE_W*BOARD_W*BOARD_H  compacted types
- num_cleared  out  $clog2(BOARD_H+1)  rows removed
- clear_mask  out  BOARD_H  bit r set if input row r was full
- score_delta  out  10  points for this clear (see Configuration)

## Operation
- States: IDLE, SCAN, FILL, DONE.
- IDLE: start=1 → latch cur_fill/cur_type into work snapshot, rd=0, wr=0, count=0, mask=0, go SCAN. start=0 → stay.
- SCAN, per cycle: row rd full (all BOARD_W fill bits 1) → mask[rd]=1, count+1, wr unchanged; else copy row rd (fill and type) into work output row wr, wr+1. rd+1. After rd=BOARD_H-1 processed → FILL.
- FILL (one cycle): every work row with index ≥ wr set fill=0, type=0. → DONE.
- DONE (one cycle): copy work output to nxt_fill/nxt_type, count to num_cleared, mask to clear_mask, compute score_delta; done=1; → IDLE.
- Rows below the lowest full row are unchanged; a board with no full row is returned identical; all rows full → all-zero board, num_cleared=BOARD_H.
- Empty cell is fill=0, type=0.
- start while busy ignored (no queueing). start in DONE cycle ignored; accepted from next IDLE cycle.
- Input buses may change after the start cycle; only the snapshot is used.
- Outputs hold last results until next DONE.

## Timing
- Reset: state IDLE; busy, done, nxt_fill, nxt_type, num_cleared, clear_mask, score_delta all 0; internal counters 0.
- Fixed latency: start sampled at cycle 0 → SCAN cycles 1..BOARD_H → FILL at BOARD_H+1 → done=1 at cycle BOARD_H+2 (22 for defaults). Independent of board contents.
- Earliest next start accepted at cycle BOARD_H+3.
- rd/wr width $clog2(BOARD_H+1); wr never exceeds rd+1.
- rst_n low mid-operation: immediate abort, all outputs to reset values, no done pulse.

## Configuration
- LINE_CLEAR_SCORE_EN defined: score_delta = 0/100/300/500/800 for num_cleared 0/1/2/3/≥4, registered with other results in DONE.
- Undefined: score_delta tied to 0; no score logic; all other behaviour identical.

## Structure
- Shared package tetris_pkg: BOARD_W, BOARD_H, TYPE_W defaults, row-fill and row-type typedefs, empty-row constants, score constants (100/300/500/800).
- One sub-module: line_clear_row_full, combinational full-row detector (BOARD_W fill bits → 1 bit), instantiated once on the rd row.

## Test plan
- Empty board, start → done at cycle 22, num_cleared=0, clear_mask=0, nxt equal to input, score_delta=0.
- Rows 0–3 full, row 4 fill 10'h001 type 3'd5 → num_cleared=4, mask=20'h0000F, nxt row 0 = 10'h001/type 5, rows 1–19 empty, score_delta=800 (0 without macro).
- Non-contiguous: rows 2, 7, 15 full, others unique patterns → num_cleared=3, mask=20'h08084, survivors compacted in order, rows 17–19 empty, score 500.
- All 20 rows full → num_cleared=20, nxt all zero, mask=20'hFFFFF, score 800.
- start pulsed at cycles 0, 5, 22 → single operation, done only at cycle 22, second run accepted at cycle 23 not 22.
- rst_n low at cycle 10 of a run → busy=0, outputs 0, no done; fresh start afterwards completes normally.
